pipeline_sequencer: RTL and testbench

Central pipeline-control FSM for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It merges the hazard unit's load-use stall and branch/jump flush requests with the instruction and data memory ready handshakes. From these it drives every pipeline-register enable and clear, so each register sees one resolved action per cycle. It also adds a post-reset pipeline fill and a data-memory wait watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipeline_sequencer_perf.sv | 42 ++++
 rtl/pipeline_sequencer.sv | 154 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } seq_state_e;

    // Encoding of a cleared pipeline register: addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Resolved per-cycle pipeline action, highest priority first
    localparam logic [2:0] PRIO_INIT  = 3'd0;
    localparam logic [2:0] PRIO_MEM   = 3'd1;
    localparam logic [2:0] PRIO_FLUSH = 3'd2;
    localparam logic [2:0] PRIO_STALL = 3'd3;
    localparam logic [2:0] PRIO_FETCH = 3'd4;
    localparam logic [2:0] PRIO_NONE  = 3'd5;

    // RUN priorities below the data-memory wait; also used for the MEM_WAIT exit cycle
    function automatic logic [2:0] resolve_run(input logic flush_br,
                                               input logic stall_ld,
                                               input logic imem_ready);
        if (flush_br)
            return PRIO_FLUSH;
        else if (stall_ld)
            return PRIO_STALL;
        else if (!imem_ready)
            return PRIO_FETCH;
        else
            return PRIO_NONE;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_perf.sv
// rtl/pipeline_sequencer_perf.sv - saturating stall/flush event counters
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall_evt_i       cycle with the PC held outside INIT
//   flush_evt_i       cycle acting on a branch/jump flush
//   perf_stall_cnt_o  saturating count of stall_evt_i cycles
//   perf_flush_cnt_o  saturating count of flush_evt_i cycles
module pipeline_sequencer_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_evt_i,
    input  logic        flush_evt_i,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt_i && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_evt_i && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - 5-stage pipeline control FSM (stall/flush/memory wait)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall_ld, flush_br         hazard unit load-use stall and branch/jump flush
//   imem_ready                 fetch data valid this cycle
//   dmem_req, dmem_ready       MEM-stage access request and completion
//   pc_en .. mem_wb_en         pipeline register load enables (Mealy)
//   if_id_clr, id_ex_clr       clear-to-NOP for IF/ID and ID/EX (Mealy)
//   mem_err                    sticky data-memory watchdog flag
//   perf_stall_cnt/flush_cnt   only with PIPELINE_SEQUENCER_PERF_EN defined
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_ld,
    input  logic        flush_br,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_clr,
    output logic        id_ex_clr,
    output logic        mem_err
`ifdef PIPELINE_SEQUENCER_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [2:0]        level;

    // Next state plus the single resolved action for this cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        level     = PRIO_INIT;
        case (state_q)
            INIT: begin
                level   = PRIO_INIT;
                state_d = RUN;
            end
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    level   = PRIO_MEM;
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    level = resolve_run(flush_br, stall_ld, imem_ready);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    level   = resolve_run(flush_br, stall_ld, imem_ready);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    // Access abandoned: the exit cycle behaves like a completion
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                    level     = resolve_run(flush_br, stall_ld, imem_ready);
                end else begin
                    level = PRIO_MEM;
                    if (cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                level   = PRIO_INIT;
                state_d = INIT;
            end
        endcase
    end

    always_comb begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        if_id_clr = 1'b0;
        id_ex_clr = 1'b0;
        case (level)
            PRIO_INIT: begin
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end
            PRIO_FLUSH: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end
            PRIO_STALL: begin
                // Hold PC and IF/ID, inject a bubble into ID/EX
                {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                id_ex_clr = 1'b1;
            end
            PRIO_FETCH: begin
                {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
                if_id_clr = 1'b1;
            end
            PRIO_NONE: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PIPELINE_SEQUENCER_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state_q != INIT) && !pc_en;
    assign flush_evt = (level == PRIO_FLUSH);

    pipeline_sequencer_perf u_perf (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_evt_i      (stall_evt),
        .flush_evt_i      (flush_evt),
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_flush_cnt_o (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_ld = 1'b0;
    logic flush_br = 1'b0;
    logic imem_ready = 1'b1;
    logic dmem_req = 1'b0;
    logic dmem_ready = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr, mem_err;
`ifdef PIPELINE_SEQUENCER_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr}
    localparam logic [6:0] O_INIT   = 7'b00000_11;
    localparam logic [6:0] O_ALL    = 7'b11111_00;
    localparam logic [6:0] O_FREEZE = 7'b00000_00;
    localparam logic [6:0] O_FLUSH  = 7'b11111_11;
    localparam logic [6:0] O_STALL  = 7'b00111_01;
    localparam logic [6:0] O_FETCH  = 7'b01111_10;

    logic [6:0] outs;
    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr};

    pipeline_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_ld   (stall_ld),
        .flush_br   (flush_br),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .id_ex_en   (id_ex_en),
        .ex_mem_en  (ex_mem_en),
        .mem_wb_en  (mem_wb_en),
        .if_id_clr  (if_id_clr),
        .id_ex_clr  (id_ex_clr),
        .mem_err    (mem_err)
`ifdef PIPELINE_SEQUENCER_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here, outputs are sampled 2 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (outs !== O_INIT) begin
            errors++;
            $display("FAIL reset_outs got=%b exp=%b", outs, O_INIT);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_err got=%b exp=0", mem_err);
        end
        tick();
        rst_n = 1'b1;
        #2;
        checks++;
        if (outs !== O_INIT) begin
            errors++;
            $display("FAIL init_cycle got=%b exp=%b", outs, O_INIT);
        end
        tick();
        #1;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL first_run got=%b exp=%b", outs, O_ALL);
        end
    endtask

    task automatic test_stall();
        stall_ld = 1'b1;
        #2;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL stall got=%b exp=%b", outs, O_STALL);
        end
        tick();
        stall_ld = 1'b0;
        #2;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL stall_release got=%b exp=%b", outs, O_ALL);
        end
        tick();
    endtask

    task automatic test_flush_over_stall();
        flush_br = 1'b1;
        stall_ld = 1'b1;
        #2;
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL flush_stall got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        flush_br = 1'b0;
        stall_ld = 1'b0;
        imem_ready = 1'b0;
        #2;
        checks++;
        if (outs !== O_FETCH) begin
            errors++;
            $display("FAIL imem_wait got=%b exp=%b", outs, O_FETCH);
        end
        tick();
        imem_ready = 1'b1;
        #2;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL imem_release got=%b exp=%b", outs, O_ALL);
        end
        tick();
    endtask

    task automatic test_one_cycle_mem();
        dmem_req = 1'b1;
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL mem_1cyc got=%b exp=%b", outs, O_ALL);
        end
        tick();
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
        #2;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL mem_1cyc_next got=%b exp=%b", outs, O_ALL);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        flush_br = 1'b1;
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (outs !== O_FREEZE) begin
                errors++;
                $display("FAIL mem_wait_freeze[%0d] got=%b exp=%b", i, outs, O_FREEZE);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL mem_wait_release got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
        flush_br = 1'b0;
        #2;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL mem_wait_after got=%b exp=%b", outs, O_ALL);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_no_err got=%b exp=0", mem_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        // RUN request cycle plus MEM_WAIT cycles 1..3 are frozen
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (outs !== O_FREEZE) begin
                errors++;
                $display("FAIL timeout_freeze[%0d] got=%b exp=%b", i, outs, O_FREEZE);
            end
            tick();
        end
        // 4th MEM_WAIT cycle is the abandon/exit cycle
        #2;
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL timeout_exit got=%b exp=%b", outs, O_ALL);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_early got=%b exp=0", mem_err);
        end
        tick();
        dmem_req = 1'b0;
        #2;
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_set got=%b exp=1", mem_err);
        end
        checks++;
        if (outs !== O_ALL) begin
            errors++;
            $display("FAIL timeout_run got=%b exp=%b", outs, O_ALL);
        end
        tick();
        tick();
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_sticky got=%b exp=1", mem_err);
        end
    endtask

    task automatic test_async_reset_in_wait();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        #2;
        checks++;
        if (outs !== O_FREEZE) begin
            errors++;
            $display("FAIL areset_prewait got=%b exp=%b", outs, O_FREEZE);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_INIT) begin
            errors++;
            $display("FAIL areset_outs got=%b exp=%b", outs, O_INIT);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_err got=%b exp=0", mem_err);
        end
        dmem_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        checks++;
        if (outs !== O_INIT) begin
            errors++;
            $display("FAIL areset_init got=%b exp=%b", outs, O_INIT);
        end
        tick();
    endtask

`ifdef PIPELINE_SEQUENCER_PERF_EN
    task automatic test_perf();
        do_reset();
        tick();
        stall_ld = 1'b1;
        tick();
        stall_ld = 1'b0;
        tick();
        stall_ld = 1'b1;
        tick();
        stall_ld = 1'b0;
        flush_br = 1'b1;
        tick();
        flush_br = 1'b0;
        tick();
        checks++;
        if (perf_stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt);
        end
        checks++;
        if (perf_flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_flush got=%0d exp=1", perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_stall();
        test_flush_over_stall();
        test_one_cycle_mem();
        test_mem_wait();
        test_timeout();
        test_async_reset_in_wait();
`ifdef PIPELINE_SEQUENCER_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
